mem_write_checker: RTL and testbench
====================================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter DATA_W, default 16, width of write_data and expected data.
REQ-002 Parameter ADDR_W, default 13, width of data_adr and expected addresses.
REQ-003 Parameter N_EXP, default 4, number of expectation entries (range 1..16).
REQ-004 Parameter ORDERED, default 1; 1 means entries must match in index order, 0 means any order.
REQ-005 Parameter TIMEOUT, default 1048576, number of RUN cycles allowed before a timeout failure.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 mem_write  in  1  processor store strobe; sampled on every rising edge.
REQ-009 data_adr  in  ADDR_W  store address.
REQ-010 write_data  in  DATA_W  store data.
REQ-011 start  in  1  one-cycle pulse that begins a check run.
REQ-012 load_en, load_idx[$clog2(N_EXP)], load_adr[ADDR_W], load_data[DATA_W]  in  expectation table write port.
REQ-013 busy  out  1  high while in RUN.
REQ-014 pass, fail  out  1 each  sticky verdict flags.
REQ-015 fail_code  out  2  00 none, 01 data mismatch, 10 timeout.
REQ-016 match_count  out  5  number of entries matched in this run.
REQ-017 write_count  out  16  stores observed in RUN; saturates at 16'hFFFF.
REQ-018 bad_adr, bad_data  out  ADDR_W, DATA_W  offending store captured on a mismatch failure.

Function
REQ-019 FSM states are IDLE, RUN, PASS, FAIL; all outputs are registered.
REQ-020 The table is written by load_en only in IDLE, PASS or FAIL; load_en in RUN is ignored.
REQ-021 On start in IDLE/PASS/FAIL: go to RUN; clear match_count, write_count, hit bits, timeout counter, fail_code, bad_adr, bad_data, pass, fail.
REQ-022 start while in RUN is ignored.
REQ-023 In RUN, a store is a cycle with mem_write=1; each store increments write_count.
REQ-024 ORDERED=1: a store to entry[ptr].adr with equal data matches, and ptr and match_count increment.
REQ-025 ORDERED=1: a store to entry[ptr].adr with different data causes FAIL with code 01, capturing bad_adr and bad_data.
REQ-026 ORDERED=1: a store to any other address is ignored, except that it is counted.
REQ-027 ORDERED=0: the candidate is the lowest-index un-hit entry with an equal address.
REQ-028 ORDERED=0: if the candidate's data is equal, its hit bit is set and match_count increments.
REQ-029 ORDERED=0: if the candidate's data differs, go to FAIL with code 01.
REQ-030 ORDERED=0: if there is no candidate, the store is ignored.
REQ-031 When match_count reaches N_EXP, go to PASS; pass rises on the edge after the completing store is sampled (latency 1).
REQ-032 The timeout counter increments every RUN cycle; at TIMEOUT-1 with no completion, go to FAIL with code 10.
REQ-033 Same-cycle priority: mismatch first, then completion, then timeout (a completing store on the timeout cycle gives PASS).
REQ-034 PASS and FAIL are held until start or reset; mem_write is ignored outside RUN.
REQ-035 Data and address compares are exact equality over the full width; X/Z handling is not required.

Reset
REQ-036 reset forces state IDLE, busy=0, pass=0, fail=0, fail_code=00, and clears all counters, bad_adr, bad_data and hit bits.
REQ-037 reset wins over start, load_en and mem_write in the same cycle.
REQ-038 reset during RUN aborts the run with no verdict.
REQ-039 Table contents are cleared to zero by reset.

Structure
REQ-040 Package chk_pkg holds the state enum, the fail_code enum (CHK_NONE, CHK_MISMATCH, CHK_TIMEOUT) and a saturating-increment function.
REQ-041 Sub-module mem_chk_table holds the N_EXP address/data registers, the hit bits, the load port and the lowest-index candidate search; the FSM, counters and verdict stay in mem_write_checker.

Verification
REQ-042 ORDERED=1, N_EXP=2, table {(220,0x4060),(100,0x0007)}, start; stores (50,0x1111), (220,0x4060), (100,0x0007) -> pass=1 one cycle after the third store, match_count=2, write_count=3.
REQ-043 Same table; store (220,0x1234) -> fail=1, fail_code=01, bad_adr=220, bad_data=0x1234; later stores do not change outputs.
REQ-044 ORDERED=0, same table; stores (100,0x0007) then (220,0x4060) -> pass=1; ORDERED=1 with the same sequence -> store to 100 ignored, no pass.
REQ-045 TIMEOUT=16, start with no stores -> fail=1, fail_code=10, busy=0 exactly 16 cycles after start.
REQ-046 TIMEOUT=16, completing store on the 16th RUN cycle -> pass=1, fail=0.
REQ-047 reset asserted mid-RUN -> all outputs return to reset values next edge; start after reset with the reloaded table runs normally.

Source files
------------

// File: rtl/mem_write_checker_pkg.sv
// Shared types for the store-stream checker: FSM states, verdict codes and counter helpers.
// Imported by the table, the interface and the checker top.
package chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } chk_state_e;

   typedef enum logic [1:0] {
      CHK_NONE     = 2'b00,
      CHK_MISMATCH = 2'b01,
      CHK_TIMEOUT  = 2'b10
   } chk_code_e;

   localparam int WCNT_W = 16;
   localparam int MCNT_W = 5;

   // Index width that stays legal for a single-entry table.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
      return (v == {WCNT_W{1'b1}}) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Store-stream, table-load and verdict signals of the memory write checker.
// master drives stores/loads/start; slave is the checker itself.
interface mem_write_checker_if
   import chk_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13,
   parameter int N_EXP  = 4
) ();
   localparam int IDX_W = idx_w(N_EXP);

   logic                mem_write;
   logic [ADDR_W-1:0]   data_adr;
   logic [DATA_W-1:0]   write_data;
   logic                start;
   logic                load_en;
   logic [IDX_W-1:0]    load_idx;
   logic [ADDR_W-1:0]   load_adr;
   logic [DATA_W-1:0]   load_data;

   logic                busy;
   logic                pass;
   logic                fail;
   logic [1:0]          fail_code;
   logic [MCNT_W-1:0]   match_count;
   logic [WCNT_W-1:0]   write_count;
   logic [ADDR_W-1:0]   bad_adr;
   logic [DATA_W-1:0]   bad_data;

   modport master (
      output mem_write, data_adr, write_data, start,
      output load_en, load_idx, load_adr, load_data,
      input  busy, pass, fail, fail_code, match_count, write_count, bad_adr, bad_data
   );

   modport slave (
      input  mem_write, data_adr, write_data, start,
      input  load_en, load_idx, load_adr, load_data,
      output busy, pass, fail, fail_code, match_count, write_count, bad_adr, bad_data
   );
endinterface

// File: rtl/mem_write_checker_table.sv
// Expectation table: N_EXP address/data entries, per-entry hit bits and the candidate search.
// Candidate is entry[ptr] when ordered, else the lowest-index un-hit entry with a matching address.
module mem_chk_table
   import chk_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 13,
   parameter int N_EXP   = 4,
   parameter int ORDERED = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_load_we,
   input  logic [idx_w(N_EXP)-1:0]   i_load_idx,
   input  logic [ADDR_W-1:0]         i_load_adr,
   input  logic [DATA_W-1:0]         i_load_data,
   input  logic                      i_clr_hits,
   input  logic                      i_set_hit,
   input  logic [MCNT_W-1:0]         i_ptr,
   input  logic [ADDR_W-1:0]         i_look_adr,
   input  logic [DATA_W-1:0]         i_look_data,
   output logic                      o_cand_vld,
   output logic                      o_cand_eq
);
   localparam int IDX_W = idx_w(N_EXP);

   logic [ADDR_W-1:0] r_adr  [N_EXP];
   logic [DATA_W-1:0] r_data [N_EXP];
   logic [N_EXP-1:0]  r_hit;

   logic              w_cand_vld;
   logic [IDX_W-1:0]  w_cand_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_EXP; i++) begin
            r_adr[i]  <= '0;
            r_data[i] <= '0;
         end
         r_hit <= '0;
      end else begin
         if (i_load_we && (int'(i_load_idx) < N_EXP)) begin
            r_adr[i_load_idx]  <= i_load_adr;
            r_data[i_load_idx] <= i_load_data;
         end
         if (i_clr_hits) begin
            r_hit <= '0;
         end else if (i_set_hit) begin
            r_hit[w_cand_idx] <= 1'b1;
         end
      end
   end

   // Descending scan so the lowest matching index is the last one written.
   always_comb begin
      w_cand_vld = 1'b0;
      w_cand_idx = '0;
      if (ORDERED != 0) begin
         if ((int'(i_ptr) < N_EXP) && (r_adr[i_ptr[IDX_W-1:0]] == i_look_adr)) begin
            w_cand_vld = 1'b1;
            w_cand_idx = i_ptr[IDX_W-1:0];
         end
      end else begin
         for (int i = N_EXP - 1; i >= 0; i--) begin
            if (!r_hit[i] && (r_adr[i] == i_look_adr)) begin
               w_cand_vld = 1'b1;
               w_cand_idx = IDX_W'(i);
            end
         end
      end
   end

   assign o_cand_vld = w_cand_vld;
   assign o_cand_eq  = (r_data[w_cand_idx] == i_look_data);

endmodule

// File: rtl/mem_write_checker.sv
// Watches a processor store stream during a run and compares it against a loaded expectation table.
// Verdict flags are registered and sticky until the next start or reset.
module mem_write_checker
   import chk_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 13,
   parameter int N_EXP   = 4,
   parameter int ORDERED = 1,
   parameter int TIMEOUT = 1048576
) (
   input  logic               clk,
   input  logic               reset,
   mem_write_checker_if.slave bus
);
   localparam int                TO_W      = $clog2(TIMEOUT + 1);
   localparam logic [MCNT_W-1:0] MATCH_ALL = MCNT_W'(N_EXP);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

   chk_state_e          r_state,      w_state_nxt;
   chk_code_e           r_fail_code,  w_fail_code_nxt;
   logic [MCNT_W-1:0]   r_match_cnt,  w_match_cnt_nxt;
   logic [WCNT_W-1:0]   r_wr_cnt,     w_wr_cnt_nxt;
   logic [TO_W-1:0]     r_to_cnt,     w_to_cnt_nxt;
   logic [ADDR_W-1:0]   r_bad_adr,    w_bad_adr_nxt;
   logic [DATA_W-1:0]   r_bad_data,   w_bad_data_nxt;
   logic                r_busy,       w_busy_nxt;
   logic                r_pass,       w_pass_nxt;
   logic                r_fail,       w_fail_nxt;

   logic                w_load_we;
   logic                w_clr_hits;
   logic                w_set_hit;
   logic                w_mismatch;
   logic                w_cand_vld;
   logic                w_cand_eq;

   assign w_load_we = bus.load_en && (r_state != ST_RUN);

   mem_chk_table #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .N_EXP   (N_EXP),
      .ORDERED (ORDERED)
   ) u_table (
      .clk         (clk),
      .reset       (reset),
      .i_load_we   (w_load_we),
      .i_load_idx  (bus.load_idx),
      .i_load_adr  (bus.load_adr),
      .i_load_data (bus.load_data),
      .i_clr_hits  (w_clr_hits),
      .i_set_hit   (w_set_hit),
      .i_ptr       (r_match_cnt),
      .i_look_adr  (bus.data_adr),
      .i_look_data (bus.write_data),
      .o_cand_vld  (w_cand_vld),
      .o_cand_eq   (w_cand_eq)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_fail_code_nxt = r_fail_code;
      w_match_cnt_nxt = r_match_cnt;
      w_wr_cnt_nxt    = r_wr_cnt;
      w_to_cnt_nxt    = r_to_cnt;
      w_bad_adr_nxt   = r_bad_adr;
      w_bad_data_nxt  = r_bad_data;
      w_busy_nxt      = r_busy;
      w_pass_nxt      = r_pass;
      w_fail_nxt      = r_fail;
      w_clr_hits      = 1'b0;
      w_set_hit       = 1'b0;
      w_mismatch      = 1'b0;

      case (r_state)
         ST_RUN: begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
            if (bus.mem_write) begin
               w_wr_cnt_nxt = sat_inc(r_wr_cnt);
               if (w_cand_vld) begin
                  if (w_cand_eq) begin
                     w_set_hit       = 1'b1;
                     w_match_cnt_nxt = r_match_cnt + 1'b1;
                  end else begin
                     w_mismatch = 1'b1;
                  end
               end
            end
            // Mismatch beats completion, which beats the timeout on the same cycle.
            if (w_mismatch) begin
               w_state_nxt     = ST_FAIL;
               w_fail_code_nxt = CHK_MISMATCH;
               w_bad_adr_nxt   = bus.data_adr;
               w_bad_data_nxt  = bus.write_data;
               w_busy_nxt      = 1'b0;
               w_fail_nxt      = 1'b1;
            end else if (w_match_cnt_nxt == MATCH_ALL) begin
               w_state_nxt = ST_PASS;
               w_busy_nxt  = 1'b0;
               w_pass_nxt  = 1'b1;
            end else if (r_to_cnt == TO_LAST) begin
               w_state_nxt     = ST_FAIL;
               w_fail_code_nxt = CHK_TIMEOUT;
               w_busy_nxt      = 1'b0;
               w_fail_nxt      = 1'b1;
            end
         end
         default: begin
            if (bus.start) begin
               w_state_nxt     = ST_RUN;
               w_fail_code_nxt = CHK_NONE;
               w_match_cnt_nxt = '0;
               w_wr_cnt_nxt    = '0;
               w_to_cnt_nxt    = '0;
               w_bad_adr_nxt   = '0;
               w_bad_data_nxt  = '0;
               w_busy_nxt      = 1'b1;
               w_pass_nxt      = 1'b0;
               w_fail_nxt      = 1'b0;
               w_clr_hits      = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_fail_code <= CHK_NONE;
         r_match_cnt <= '0;
         r_wr_cnt    <= '0;
         r_to_cnt    <= '0;
         r_bad_adr   <= '0;
         r_bad_data  <= '0;
         r_busy      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_fail_code <= w_fail_code_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_wr_cnt    <= w_wr_cnt_nxt;
         r_to_cnt    <= w_to_cnt_nxt;
         r_bad_adr   <= w_bad_adr_nxt;
         r_bad_data  <= w_bad_data_nxt;
         r_busy      <= w_busy_nxt;
         r_pass      <= w_pass_nxt;
         r_fail      <= w_fail_nxt;
      end
   end

   assign bus.busy        = r_busy;
   assign bus.pass        = r_pass;
   assign bus.fail        = r_fail;
   assign bus.fail_code   = r_fail_code;
   assign bus.match_count = r_match_cnt;
   assign bus.write_count = r_wr_cnt;
   assign bus.bad_adr     = r_bad_adr;
   assign bus.bad_data    = r_bad_data;

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives one store stream into an ordered and an any-order checker side by side and
// scoreboards both against expectations queued alongside the stimulus.
module tb_mem_write_checker;
   import chk_pkg::*;

   localparam int DW = 16;
   localparam int AW = 13;
   localparam int NE = 2;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset;
   logic                   d_wr, d_start, d_ld;
   logic [idx_w(NE)-1:0]   d_idx;
   logic [AW-1:0]          d_adr;
   logic [DW-1:0]          d_dat;

   mem_write_checker_if #(.DATA_W(DW), .ADDR_W(AW), .N_EXP(NE)) if_o ();
   mem_write_checker_if #(.DATA_W(DW), .ADDR_W(AW), .N_EXP(NE)) if_a ();

   assign if_o.mem_write  = d_wr;    assign if_a.mem_write  = d_wr;
   assign if_o.data_adr   = d_adr;   assign if_a.data_adr   = d_adr;
   assign if_o.write_data = d_dat;   assign if_a.write_data = d_dat;
   assign if_o.start      = d_start; assign if_a.start      = d_start;
   assign if_o.load_en    = d_ld;    assign if_a.load_en    = d_ld;
   assign if_o.load_idx   = d_idx;   assign if_a.load_idx   = d_idx;
   assign if_o.load_adr   = d_adr;   assign if_a.load_adr   = d_adr;
   assign if_o.load_data  = d_dat;   assign if_a.load_data  = d_dat;

   mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .N_EXP(NE), .ORDERED(1), .TIMEOUT(TO))
      dut_o (.clk(clk), .reset(reset), .bus(if_o));
   mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .N_EXP(NE), .ORDERED(0), .TIMEOUT(TO))
      dut_a (.clk(clk), .reset(reset), .bus(if_a));

   typedef struct packed {
      logic          busy;
      logic          pass;
      logic          fail;
      logic [1:0]    code;
      logic [4:0]    mcnt;
      logic [15:0]   wcnt;
      logic [AW-1:0] badr;
      logic [DW-1:0] bdat;
   } obs_t;

   typedef struct packed {
      logic          rst;
      logic          start;
      logic          wr;
      logic          ld;
      logic          idx;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } vec_t;

   vec_t  q_stim[$];
   obs_t  q_o[$];
   obs_t  q_a[$];
   string q_tag[$];

   int n_vec = 0;
   int n_err = 0;

   function automatic obs_t mk(input int b, p, f, c, m, w, ba, bd);
      obs_t s;
      s.busy = 1'(b);  s.pass = 1'(p);  s.fail = 1'(f);  s.code = 2'(c);
      s.mcnt = 5'(m);  s.wcnt = 16'(w); s.badr = AW'(ba); s.bdat = DW'(bd);
      return s;
   endfunction

   function automatic vec_t vec(input int r, s, w, l, i, a, d);
      vec_t v;
      v.rst = 1'(r); v.start = 1'(s); v.wr = 1'(w); v.ld = 1'(l); v.idx = 1'(i);
      v.adr = AW'(a); v.dat = DW'(d);
      return v;
   endfunction

   function automatic vec_t idle();                     return vec(0, 0, 0, 0, 0, 0, 0); endfunction
   function automatic vec_t go();                       return vec(0, 1, 0, 0, 0, 0, 0); endfunction
   function automatic vec_t st(input int a, d);         return vec(0, 0, 1, 0, 0, a, d); endfunction
   function automatic vec_t ld(input int i, a, d);      return vec(0, 0, 0, 1, i, a, d); endfunction

   function automatic obs_t snap(input bit any);
      obs_t s;
      s.busy = any ? if_a.busy        : if_o.busy;
      s.pass = any ? if_a.pass        : if_o.pass;
      s.fail = any ? if_a.fail        : if_o.fail;
      s.code = any ? if_a.fail_code   : if_o.fail_code;
      s.mcnt = any ? if_a.match_count : if_o.match_count;
      s.wcnt = any ? if_a.write_count : if_o.write_count;
      s.badr = any ? if_a.bad_adr     : if_o.bad_adr;
      s.bdat = any ? if_a.bad_data    : if_o.bad_data;
      return s;
   endfunction

   task automatic push(input string t, input vec_t s, input obs_t eo, input obs_t ea);
      q_tag.push_back(t); q_stim.push_back(s); q_o.push_back(eo); q_a.push_back(ea);
   endtask

   task automatic drive(input vec_t s);
      reset = s.rst; d_start = s.start; d_wr = s.wr; d_ld = s.ld;
      d_idx = s.idx; d_adr = s.adr; d_dat = s.dat;
      @(posedge clk);
      #1;
   endtask

   localparam obs_t Z = '0;

   task automatic test_reset();
      obs_t g, e; string t;
      push("rst_wins",   vec(1, 1, 1, 1, 0, 5, 5), Z, Z);
      push("rst_hold",   vec(1, 0, 0, 0, 0, 0, 0), Z, Z);
      push("start",      go(),        mk(1,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0));
      push("zero_table", st(0, 0),    mk(1,0,0,0,1,1,0,0), mk(1,0,0,0,1,1,0,0));
      while (q_stim.size() > 0) begin
         t = q_tag.pop_front();
         drive(q_stim.pop_front());
         g = snap(1'b0); e = q_o.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s ord: got %h want %h", t, g, e); end
         g = snap(1'b1); e = q_a.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s any: got %h want %h", t, g, e); end
      end
   endtask

   task automatic test_run_guard();
      obs_t g, e; string t;
      push("ld_start_in_run", vec(0, 1, 0, 1, 1, 300, 'hAAAA),
           mk(1,0,0,0,1,1,0,0), mk(1,0,0,0,1,1,0,0));
      push("complete_zero", st(0, 0), mk(0,1,0,0,2,2,0,0), mk(0,1,0,0,2,2,0,0));
      while (q_stim.size() > 0) begin
         t = q_tag.pop_front();
         drive(q_stim.pop_front());
         g = snap(1'b0); e = q_o.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s ord: got %h want %h", t, g, e); end
         g = snap(1'b1); e = q_a.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s any: got %h want %h", t, g, e); end
      end
   endtask

   task automatic test_ordered_pass();
      obs_t g, e; string t;
      push("load0",     ld(0, 220, 'h4060), mk(0,1,0,0,2,2,0,0), mk(0,1,0,0,2,2,0,0));
      push("load1",     ld(1, 100, 'h0007), mk(0,1,0,0,2,2,0,0), mk(0,1,0,0,2,2,0,0));
      push("start",     go(),               mk(1,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0));
      push("other_adr", st(50, 'h1111),     mk(1,0,0,0,0,1,0,0), mk(1,0,0,0,0,1,0,0));
      push("match0",    st(220, 'h4060),    mk(1,0,0,0,1,2,0,0), mk(1,0,0,0,1,2,0,0));
      push("match1",    st(100, 'h0007),    mk(0,1,0,0,2,3,0,0), mk(0,1,0,0,2,3,0,0));
      push("pass_held", st(220, 'h1234),    mk(0,1,0,0,2,3,0,0), mk(0,1,0,0,2,3,0,0));
      while (q_stim.size() > 0) begin
         t = q_tag.pop_front();
         drive(q_stim.pop_front());
         g = snap(1'b0); e = q_o.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s ord: got %h want %h", t, g, e); end
         g = snap(1'b1); e = q_a.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s any: got %h want %h", t, g, e); end
      end
   endtask

   task automatic test_mismatch();
      obs_t g, e, f; string t;
      f = mk(0, 0, 1, 1, 0, 1, 220, 'h1234);
      push("start",      go(),            mk(1,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0));
      push("bad_data",   st(220, 'h1234), f, f);
      push("fail_held",  st(100, 'h9999), f, f);
      push("fail_idle",  idle(),          f, f);
      while (q_stim.size() > 0) begin
         t = q_tag.pop_front();
         drive(q_stim.pop_front());
         g = snap(1'b0); e = q_o.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s ord: got %h want %h", t, g, e); end
         g = snap(1'b1); e = q_a.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s any: got %h want %h", t, g, e); end
      end
   endtask

   // Ordered checker ignores the out-of-order store and then times out on RUN cycle 16.
   task automatic test_any_order();
      obs_t g, e; string t;
      push("start",   go(),            mk(1,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0));
      push("ooo_100", st(100, 'h0007), mk(1,0,0,0,0,1,0,0), mk(1,0,0,0,1,1,0,0));
      push("ooo_220", st(220, 'h4060), mk(1,0,0,0,1,2,0,0), mk(0,1,0,0,2,2,0,0));
      for (int k = 3; k <= TO; k++)
         push($sformatf("ord_wait%0d", k), idle(),
              (k < TO) ? mk(1,0,0,0,1,2,0,0) : mk(0,0,1,2,1,2,0,0), mk(0,1,0,0,2,2,0,0));
      while (q_stim.size() > 0) begin
         t = q_tag.pop_front();
         drive(q_stim.pop_front());
         g = snap(1'b0); e = q_o.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s ord: got %h want %h", t, g, e); end
         g = snap(1'b1); e = q_a.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s any: got %h want %h", t, g, e); end
      end
   endtask

   task automatic test_timeout();
      obs_t g, e, x; string t;
      push("start", go(), mk(1,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0));
      for (int k = 1; k <= TO + 1; k++) begin
         x = (k < TO) ? mk(1,0,0,0,0,0,0,0) : mk(0,0,1,2,0,0,0,0);
         push($sformatf("to_cyc%0d", k), idle(), x, x);
      end
      while (q_stim.size() > 0) begin
         t = q_tag.pop_front();
         drive(q_stim.pop_front());
         g = snap(1'b0); e = q_o.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s ord: got %h want %h", t, g, e); end
         g = snap(1'b1); e = q_a.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s any: got %h want %h", t, g, e); end
      end
   endtask

   // Completion on the cycle the timeout would fire must win.
   task automatic test_timeout_edge();
      obs_t g, e, x; string t;
      x = mk(1,0,0,0,0,0,0,0);
      push("start", go(), x, x);
      for (int k = 1; k <= TO - 2; k++) push($sformatf("edge_cyc%0d", k), idle(), x, x);
      push("edge_m0",   st(220, 'h4060), mk(1,0,0,0,1,1,0,0), mk(1,0,0,0,1,1,0,0));
      push("edge_done", st(100, 'h0007), mk(0,1,0,0,2,2,0,0), mk(0,1,0,0,2,2,0,0));
      while (q_stim.size() > 0) begin
         t = q_tag.pop_front();
         drive(q_stim.pop_front());
         g = snap(1'b0); e = q_o.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s ord: got %h want %h", t, g, e); end
         g = snap(1'b1); e = q_a.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s any: got %h want %h", t, g, e); end
      end
   endtask

   task automatic test_reset_mid_run();
      obs_t g, e, b; string t;
      b = mk(1,0,0,0,0,0,0,0);
      push("start",       go(),                        b, b);
      push("m0",          st(220, 'h4060),             mk(1,0,0,0,1,1,0,0), mk(1,0,0,0,1,1,0,0));
      push("rst_abort",   vec(1, 0, 1, 0, 0, 100, 7),  Z, Z);
      push("idle_after",  idle(),                      Z, Z);
      push("wr_in_idle",  st(220, 'h4060),             Z, Z);
      push("reload0",     ld(0, 220, 'h4060),          Z, Z);
      push("reload1",     ld(1, 100, 'h0007),          Z, Z);
      push("restart",     go(),                        b, b);
      push("rr_m0",       st(220, 'h4060),             mk(1,0,0,0,1,1,0,0), mk(1,0,0,0,1,1,0,0));
      push("rr_done",     st(100, 'h0007),             mk(0,1,0,0,2,2,0,0), mk(0,1,0,0,2,2,0,0));
      while (q_stim.size() > 0) begin
         t = q_tag.pop_front();
         drive(q_stim.pop_front());
         g = snap(1'b0); e = q_o.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s ord: got %h want %h", t, g, e); end
         g = snap(1'b1); e = q_a.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL %s any: got %h want %h", t, g, e); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no end want end");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; d_wr = 1'b0; d_start = 1'b0; d_ld = 1'b0;
      d_idx = '0; d_adr = '0; d_dat = '0;
      @(negedge clk);
      test_reset();
      test_run_guard();
      test_ordered_pass();
      test_mismatch();
      test_any_order();
      test_timeout();
      test_timeout_edge();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
